// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
// The arbiter top and its priority picker both import this package.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // One-hot decode of a requester index
    function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = 4'b0000;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: searches ptr+1 .. ptr+4 (mod 4) for the
// first set request, optionally ignoring one masked requester.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic [SEL_W-1:0]   mask_idx,
    input  logic               mask_en,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] mask_vec_s;
    logic [NUM_REQ-1:0] cand_s;
    logic [SEL_W-1:0]   probe_s;

    assign mask_vec_s = mask_en ? onehot4(mask_idx) : 4'b0000;
    assign cand_s     = req & ~mask_vec_s;

    // Walk from lowest to highest priority so the nearest hit after ptr wins last
    always_comb begin
        idx     = ptr;
        any     = 1'b0;
        probe_s = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            probe_s = ptr + SEL_W'(k);
            idx     = cand_s[probe_s] ? probe_s : idx;
            any     = any | cand_s[probe_s];
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin select sequencer for a 4:1 mux with a per-grant hold limit.
// Grant, select and valid are registered; q follows the registered select.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [3:0]   d,
    output logic [3:0]   grant,
    output logic [1:0]   select,
    output logic         valid,
    output logic         q
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e         state_r,    state_nxt_s;
    logic [SEL_W-1:0]   ptr_r,      ptr_nxt_s;
    logic [CNT_W-1:0]   hold_cnt_r, hold_nxt_s;
    logic [NUM_REQ-1:0] grant_r,    grant_nxt_s;
    logic [SEL_W-1:0]   select_r,   select_nxt_s;
    logic               valid_r,    valid_nxt_s;

    logic [SEL_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               mask_en_s;

    // While granted, the current holder is excluded so "any" means "someone else waits"
    assign mask_en_s = (state_r == GRANT);

    rr_pick4 u_pick (
        .req      (req),
        .ptr      (ptr_r),
        .mask_idx (select_r),
        .mask_en  (mask_en_s),
        .idx      (pick_idx_s),
        .any      (pick_any_s)
    );

    // Next-state, pointer, hold counter and output register values
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        hold_nxt_s   = hold_cnt_r;
        grant_nxt_s  = grant_r;
        select_nxt_s = select_r;
        valid_nxt_s  = valid_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s  = GRANT;
                    select_nxt_s = pick_idx_s;
                    grant_nxt_s  = onehot4(pick_idx_s);
                    valid_nxt_s  = 1'b1;
                    hold_nxt_s   = '0;
                end else begin
                    grant_nxt_s  = 4'b0000;
                    valid_nxt_s  = 1'b0;
                    hold_nxt_s   = '0;
                end
            end
            GRANT: begin
                if (!req[select_r]) begin
                    ptr_nxt_s  = select_r;
                    hold_nxt_s = '0;
                    if (pick_any_s) begin
                        select_nxt_s = pick_idx_s;
                        grant_nxt_s  = onehot4(pick_idx_s);
                        valid_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                        grant_nxt_s = 4'b0000;
                        valid_nxt_s = 1'b0;
                    end
                end else if (pick_any_s && (hold_cnt_r == HOLD_LAST)) begin
                    ptr_nxt_s    = select_r;
                    hold_nxt_s   = '0;
                    select_nxt_s = pick_idx_s;
                    grant_nxt_s  = onehot4(pick_idx_s);
                end else if (!pick_any_s) begin
                    // Lone holder: count up but park at the limit
                    hold_nxt_s = (hold_cnt_r == HOLD_LAST) ? hold_cnt_r
                                                           : hold_cnt_r + CNT_W'(1);
                end else begin
                    hold_nxt_s = hold_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                ptr_nxt_s    = 2'b11;
                hold_nxt_s   = '0;
                grant_nxt_s  = 4'b0000;
                select_nxt_s = 2'b00;
                valid_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset restores requester 0 as first priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            ptr_r      <= 2'b11;
            hold_cnt_r <= '0;
            grant_r    <= 4'b0000;
            select_r   <= 2'b00;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            grant_r    <= grant_nxt_s;
            select_r   <= select_nxt_s;
            valid_r    <= valid_nxt_s;
        end
    end

    assign grant  = grant_r;
    assign select = select_r;
    assign valid  = valid_r;
    assign q      = valid_r ? d[select_r] : 1'b0;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4-to-1 mux output between four requesters.
- Each requester raises a request; the block grants exactly one at a time.
- The block drives the mux select and presents the granted requester's data on q.
- A hold limit stops one requester from starving the others.
- Sits in front of the 4:1 mux datapath as its select sequencer.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles while another request is pending. Legal range 1..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- req, input, 4: request per requester; req[i] belongs to requester i.
- d, input, 4: data bit per requester; d[i] belongs to requester i.
- grant, output, 4: one-hot grant, registered; all zeros when idle.
- select, output, 2: registered mux select; the index of the granted requester.
- valid, output, 1: high while a grant is active.
- q, output, 1: equals d[select] when valid is high, otherwise 0. Combinational from the registered select.

Behaviour:
Reset (synchronous, takes priority over everything else):
- state = IDLE, grant = 4'b0000, select = 2'b00, valid = 0, q = 0.
- ptr = 2'b11, so requester 0 has first priority after reset.
- hold_cnt = 0.
- A reset asserted mid-grant drops the grant at that edge. No partial-state carry-over.

Priority pick (combinational):
- Search order is ptr+1, ptr+2, ptr+3, ptr+4 (= ptr), all modulo 4.
- The winner is the first index in that order with its request set.
- The pick also reports "any": high when at least one candidate request is set.

States:
- IDLE: valid = 0.
  - If any req is set, the next edge moves to GRANT with select = winner, grant = one-hot(winner), hold_cnt = 0.
  - Latency from req rising to grant is 1 cycle.
- GRANT: valid = 1. Evaluate in this order each cycle:
  1. req[select] = 0 (release): set ptr <= select. Run the pick with req[select] masked. If another request is present, hand off directly at the next edge to the winner, with hold_cnt = 0 and no dead cycle. Otherwise go to IDLE, clearing grant and valid; select keeps its last value.
  2. req[select] = 1 and hold_cnt = MAX_HOLD-1 and another request is pending (forced handoff): set ptr <= select and hand off to the masked-pick winner, with hold_cnt = 0.
  3. req[select] = 1 and no other request is pending: keep the grant. hold_cnt saturates at MAX_HOLD-1.
  4. Otherwise, keep the grant and increment hold_cnt.

Invariants:
- grant is always zero or one-hot.
- grant[select] = valid.
- select changes only at a grant boundary.
- New requests arriving mid-grant never preempt the current grant before a release or the hold limit.
- Simultaneous release and a new request from the releasing requester: the releasing requester is excluded for that arbitration; it wins next only if it is the only requester left.

Decomposition:
- Shared package mux_arb_pkg:
  - state localparams IDLE = 1'b0, GRANT = 1'b1;
  - NUM_REQ = 4;
  - SEL_W = 2.
- One sub-module, rr_pick4: purely combinational.
  - Inputs: req[3:0], ptr[1:0], mask_idx[1:0], mask_en.
  - Outputs: idx[1:0], any.
  - Instantiated once in mux4_rr_arbiter.
- The state register, ptr, hold counter and output registers all live in the top block.

Test Plan:
1. Reset, then req = 4'b0101 held, d = 4'b0001 → grant = 0001 and select = 00 one cycle later, q = 1. Requester 2 is granted only after requester 0 is held MAX_HOLD = 8 cycles.
2. Fairness: req = 4'b1111 held for 40 cycles → grant sequence 0, 1, 2, 3, 0, each held 8 cycles, with no gap in valid.
3. Release handoff: grant on requester 1, drop req[1] while req[3] = 1 → the next edge gives grant = 1000 and select = 11, with valid staying high.
4. Idle return: the only requester 2 drops req → the next edge gives grant = 0000, valid = 0, q = 0. A later req = 4'b0100 re-grants requester 2 after 1 cycle.
5. Lone holder: req = 4'b0010 for 20 cycles → grant stays 0010 throughout and hold_cnt saturates at 7. Raising req[0] then hands off to requester 0 at the next edge.
6. Reset mid-grant: reset = 1 for 1 cycle during the grant to requester 3 → all outputs return to reset values at that edge. Then req = 4'b1001 grants requester 0 first, since ptr = 11.
